// File: rtl/ram_stream_reader.sv
// Streams a contiguous (or, with RAM_READER_STRIDE_EN, strided) block of tile-RAM words to a valid/ready sink.
// Latency: start to first ram_en is 1 cycle, first out_valid is 3 cycles, then one word per cycle.
// Backpressure: a 2-entry skid FIFO holds words; reads stop when FIFO plus inflight would exceed 2.

// Generic synchronous FIFO with a combinational head output.
// Latency: a push is visible at the head on the following cycle.
// Backpressure: push is ignored when full unless a pop frees the slot in the same cycle.
module ram_reader_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_dat,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head_dat,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// Tile-RAM block reader: issues reads from a latched base/length and streams the results out in order.
// Latency: ram_rdata is pushed one cycle after ram_en; done pulses the cycle after the last word leaves.
// Backpressure: out_ready low stalls issue once two words are buffered or in flight; nothing is dropped.
module ram_stream_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  length,
`ifdef RAM_READER_STRIDE_EN
    input  logic [ADDR_WIDTH-1:0] stride,
`endif
    output logic                  busy,
    output logic                  done,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
);
    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        FINISH
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [ADDR_WIDTH-1:0]   step;
    logic [LEN_WIDTH-1:0]    remaining_q;
    logic                    inflight_q;
    logic                    inflight_last_q;
    logic                    issue;
    logic                    last_issue;
    logic                    pop;
    logic [2:0]              occupancy;
    logic [1:0]              fifo_count;
    logic                    fifo_empty;
    logic [DATA_WIDTH:0]     fifo_head;

`ifdef RAM_READER_STRIDE_EN
    logic [ADDR_WIDTH-1:0]   stride_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stride_q <= '0;
        end else if (state_q == IDLE && start) begin
            stride_q <= stride;
        end
    end

    assign step = stride_q;
`else
    assign step = ADDR_WIDTH'(1);
`endif

    // Each issued read owns a FIFO slot from the issue cycle until it is popped.
    assign pop        = out_valid && out_ready;
    assign occupancy  = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
    assign last_issue = (remaining_q == LEN_WIDTH'(1));
    assign issue      = (state_q == ISSUE) && (occupancy < 3'd2);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            remaining_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            inflight_q      <= issue;
            inflight_last_q <= issue && last_issue;
            if (state_q == IDLE && start) begin
                addr_q      <= base_addr;
                remaining_q <= length;
            end else if (issue) begin
                addr_q      <= addr_q + step;
                remaining_q <= remaining_q - LEN_WIDTH'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                // A zero-length request passes through DRAIN so done keeps its fixed two-cycle offset.
                if (start) begin
                    state_d = (length == '0) ? DRAIN : ISSUE;
                end
            end
            ISSUE: begin
                if (issue && last_issue) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Leave as the final word is popped so done follows it directly.
                if (!inflight_q && ((fifo_count == 2'd0) || (fifo_count == 2'd1 && pop))) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    ram_reader_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (2)
    ) u_skid_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (inflight_q),
        .push_dat ({inflight_last_q, ram_rdata}),
        .pop      (pop),
        .head_dat (fifo_head),
        .count    (fifo_count),
        .empty    (fifo_empty)
    );

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FINISH);
    assign ram_en    = issue;
    assign ram_we    = 1'b0;
    assign ram_addr  = addr_q;
    assign ram_wdata = '0;
    assign out_valid = !fifo_empty;
    assign out_data  = fifo_head[DATA_WIDTH-1:0];
    assign out_last  = fifo_head[DATA_WIDTH] && out_valid;
endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader: RAM model plus a queue-based expected stream built from base/length/stride.
module tb_ram_stream_reader;
    localparam int DW    = 16;
    localparam int AW    = 10;
    localparam int LW    = 11;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [LW-1:0] length;
`ifdef RAM_READER_STRIDE_EN
    logic [AW-1:0] stride;
`endif
    logic          busy;
    logic          done;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;

    logic [DW-1:0] ram [DEPTH];
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_en) ram_rdata <= ram[ram_addr];
    end

    ram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
`ifdef RAM_READER_STRIDE_EN
        .stride    (stride),
`endif
        .busy      (busy),
        .done      (done),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},      busy,      0);
        check({tag, "_done"},      done,      0);
        check({tag, "_ram_en"},    ram_en,    0);
        check({tag, "_ram_we"},    ram_we,    0);
        check({tag, "_ram_wdata"}, ram_wdata, 0);
        check({tag, "_ram_addr"},  ram_addr,  0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"},  out_data,  0);
        check({tag, "_out_last"},  out_last,  0);
    endtask

    // mode 0: out_ready held high; 1: random; 2: repeating 1,0,0,1,0,1.
    task automatic run_xfer(input int base, input int len, input int strd, input int mode, input bit poke);
        int            exp_addr[$];
        logic [DW-1:0] exp_data[$];
        int            issued, popped, first_valid, last_cyc, done_cyc, a;
        bit            any_valid, prev_stall, rdy, done_seen;
        logic [DW-1:0] prev_data;
        logic          prev_last;
        bit            pat[6];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int k = 0; k < len; k++) begin
            a = (base + k * strd) % DEPTH;
            exp_addr.push_back(a);
            exp_data.push_back(ram[a]);
        end
        issued = 0; popped = 0; first_valid = -1; last_cyc = -1; done_cyc = -1;
        any_valid = 0; prev_stall = 0; done_seen = 0;
        prev_data = '0; prev_last = 0;

        next_cycle();
        start     = 1'b1;
        base_addr = AW'(base);
        length    = LW'(len);
`ifdef RAM_READER_STRIDE_EN
        stride    = AW'(strd);
`endif
        out_ready = 1'b1;
        @(negedge clk);
        check("idle_busy", busy, 0);

        for (int c = 1; c < len * 6 + 20 && !done_seen; c++) begin
            next_cycle();
            start = poke && (c == 3);
            if (poke && c == 3) begin
                base_addr = AW'(base + 7);
                length    = LW'(2);
            end
            if (mode == 0)      rdy = 1'b1;
            else if (mode == 1) rdy = 1'($urandom_range(0, 1));
            else                rdy = pat[(c - 1) % 6];
            out_ready = rdy;
            @(negedge clk);
            if (c == 1) check("busy_after_start", busy, 1);
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_data",  out_data,  prev_data);
                check("stall_last",  out_last,  prev_last);
            end
            if (ram_en) begin
                if (issued < len) check("ram_addr", ram_addr, exp_addr[issued]);
                else              check("extra_issue", issued + 1, len);
                issued++;
            end
            if (out_valid && !any_valid) begin
                any_valid   = 1;
                first_valid = c;
            end
            if (out_valid && out_ready) begin
                if (popped < len) begin
                    check("out_data", out_data, exp_data[popped]);
                    check("out_last", out_last, popped == len - 1);
                end else begin
                    check("extra_word", popped + 1, len);
                end
                if (out_last) last_cyc = c;
                popped++;
            end
            check("occupancy", (issued - popped) <= 2, 1);
            if (done) begin
                check("done_vs_valid", out_valid, 0);
                done_seen = 1;
                done_cyc  = c;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end

        check("done_seen", done_seen, 1);
        check("issued", issued, len);
        check("popped", popped, len);
        if (len == 0) check("zero_no_valid", any_valid, 0);
        if (mode == 0) begin
            check("done_cycle", done_cyc, (len == 0) ? 2 : 3 + len);
            if (len > 0) begin
                check("first_valid_cycle", first_valid, 3);
                check("last_cycle", last_cyc, 2 + len);
            end
        end
        next_cycle();
        start     = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("busy_after_done", busy, 0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        length    = '0;
        out_ready = 1'b0;
`ifdef RAM_READER_STRIDE_EN
        stride    = AW'(1);
`endif
        for (int i = 0; i < DEPTH; i++) ram[i] = DW'(i + 100);

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");

        run_xfer(5, 4, 1, 0, 0);
        run_xfer(1022, 4, 1, 0, 0);
        run_xfer(100, 8, 1, 2, 0);
        run_xfer(50, 0, 1, 0, 0);
        run_xfer(200, 6, 1, 0, 1);

        // Synchronous reset in cycle 5 of a length-10 run.
        next_cycle();
        start     = 1'b1;
        base_addr = AW'(300);
        length    = LW'(10);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            next_cycle();
            start = 1'b0;
        end
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst");
        run_xfer(300, 10, 1, 0, 0);

`ifdef RAM_READER_STRIDE_EN
        run_xfer(0, 4, 3, 0, 0);
        run_xfer(0, 4, 0, 0, 0);
`endif

        for (int i = 0; i < DEPTH; i++) ram[i] = DW'($urandom);
        run_xfer(1015, 20, 1, 1, 0);
        for (int t = 0; t < 6; t++) begin
`ifdef RAM_READER_STRIDE_EN
            run_xfer($urandom_range(0, DEPTH - 1), $urandom_range(1, 24), $urandom_range(0, DEPTH - 1), 1, 0);
`else
            run_xfer($urandom_range(0, DEPTH - 1), $urandom_range(1, 24), 1, 1, 0);
`endif
        end
        run_xfer($urandom_range(0, DEPTH - 1), 12, 1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
